// File: rtl/gh_note_pkg.sv
// rtl/gh_note_pkg.sv - shared state encoding, playfield geometry and lane-to-x mapping
package gh_note_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam logic [2:0]     LANES      = 3'd5;
    localparam logic [X_W-1:0] LANE_X0    = 10'd160;
    localparam logic [X_W-1:0] LANE_PITCH = 10'd64;
    localparam logic [9:0]     NOTE_SPEED = 10'd2;
    localparam logic [9:0]     SCREEN_H   = 10'd480;
    localparam logic [Y_W-1:0] HIT_Y_MIN  = 9'd400;
    localparam logic [Y_W-1:0] HIT_Y_MAX  = 9'd440;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_SCAN,
        ST_REPORT
    } state_e;

    function automatic logic [X_W-1:0] lane_to_x(input logic [2:0] lane);
        return LANE_X0 + ({7'd0, lane} * LANE_PITCH);
    endfunction

endpackage

// File: rtl/slot_alloc_encoder.sv
// rtl/slot_alloc_encoder.sv - lowest-index free slot finder over the slot valid vector
module slot_alloc_encoder #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  slot_valid_i,
    output logic [SW-1:0] free_idx_o,
    output logic          any_free_o
);

    // Descending loop so the lowest free index is the last one written.
    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!slot_valid_i[i]) begin
                free_idx_o = SW'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_slot_scheduler.sv
// rtl/note_slot_scheduler.sv - falling-note slot pool: spawn, per-frame advance, miss retire, strum resolve
module note_slot_scheduler
    import gh_note_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     spawn_valid,
    input  logic [2:0]               spawn_lane,
    output logic                     spawn_ready,
    input  logic                     strum_valid,
    input  logic [2:0]               strum_lane,
    output logic                     strum_ready,
    output logic                     hit,
    output logic                     bad_strum,
    output logic                     miss,
    output logic                     busy,
    output logic [NUM_SLOTS-1:0]     slot_valid,
    output logic [NUM_SLOTS*X_W-1:0] slot_x,
    output logic [NUM_SLOTS*Y_W-1:0] slot_y
);

    localparam int             SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SW-1:0]  LAST_IDX = SW'(NUM_SLOTS - 1);

    state_e                state_q, state_d;
    logic [SW-1:0]         idx_q, idx_d;
    logic                  tick_pend_q, tick_pend_d;
    logic [2:0]            lane_q, lane_d;
    logic                  best_found_q, best_found_d;
    logic [SW-1:0]         best_idx_q, best_idx_d;
    logic [Y_W-1:0]        best_y_q, best_y_d;
    logic [NUM_SLOTS-1:0]  valid_q, valid_d;
    logic [X_W-1:0]        x_q [NUM_SLOTS];
    logic [X_W-1:0]        x_d [NUM_SLOTS];
    logic [Y_W-1:0]        y_q [NUM_SLOTS];
    logic [Y_W-1:0]        y_d [NUM_SLOTS];

    logic                  idle, tick_go, any_free, spawn_fire, strum_fire, candidate;
    logic [SW-1:0]         free_idx;
    logic [X_W-1:0]        cur_x;
    logic [Y_W-1:0]        cur_y;
    logic [9:0]            ny;

    slot_alloc_encoder #(.N(NUM_SLOTS), .SW(SW)) u_alloc (
        .slot_valid_i (valid_q),
        .free_idx_o   (free_idx),
        .any_free_o   (any_free)
    );

    assign idle        = (state_q == ST_IDLE);
    assign tick_go     = frame_tick | tick_pend_q;
    assign spawn_ready = idle & ~tick_go & any_free;
    assign strum_ready = idle & ~tick_go;
    assign spawn_fire  = spawn_valid & spawn_ready;
    assign strum_fire  = strum_valid & strum_ready;
    assign busy        = ~idle;

    assign cur_x     = x_q[idx_q];
    assign cur_y     = y_q[idx_q];
    assign ny        = {1'b0, cur_y} + NOTE_SPEED;
    assign candidate = valid_q[idx_q] && (cur_x == lane_to_x(lane_q))
                       && (cur_y >= HIT_Y_MIN) && (cur_y <= HIT_Y_MAX);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tick_pend_d  = tick_pend_q | (frame_tick & ~idle);
        lane_d       = lane_q;
        best_found_d = best_found_q;
        best_idx_d   = best_idx_q;
        best_y_d     = best_y_q;
        valid_d      = valid_q;
        x_d          = x_q;
        y_d          = y_q;
        hit          = 1'b0;
        bad_strum    = 1'b0;
        miss         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_go) begin
                    state_d     = ST_ADVANCE;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end else begin
                    if (strum_fire) begin
                        state_d      = ST_SCAN;
                        idx_d        = '0;
                        lane_d       = strum_lane;
                        best_found_d = 1'b0;
                    end
                    // Out-of-range lanes complete the handshake without allocating.
                    if (spawn_fire && (spawn_lane < LANES)) begin
                        valid_d[free_idx] = 1'b1;
                        x_d[free_idx]     = lane_to_x(spawn_lane);
                        y_d[free_idx]     = '0;
                    end
                end
            end
            ST_ADVANCE: begin
                if (valid_q[idx_q]) begin
                    if (ny >= SCREEN_H) begin
                        valid_d[idx_q] = 1'b0;
                        miss           = 1'b1;
                    end else begin
                        y_d[idx_q] = ny[Y_W-1:0];
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                // Strict > keeps the lower index on equal y.
                if (candidate && (!best_found_q || (cur_y > best_y_q))) begin
                    best_found_d = 1'b1;
                    best_idx_d   = idx_q;
                    best_y_d     = cur_y;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_REPORT;
                    idx_d   = '0;
                end
            end
            ST_REPORT: begin
                if (best_found_q) begin
                    valid_d[best_idx_q] = 1'b0;
                    hit                 = 1'b1;
                end else begin
                    bad_strum = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tick_pend_q  <= 1'b0;
            lane_q       <= '0;
            best_found_q <= 1'b0;
            best_idx_q   <= '0;
            best_y_q     <= '0;
            valid_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tick_pend_q  <= tick_pend_d;
            lane_q       <= lane_d;
            best_found_q <= best_found_d;
            best_idx_q   <= best_idx_d;
            best_y_q     <= best_y_d;
            valid_q      <= valid_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    always_comb begin
        slot_valid = valid_q;
        slot_x     = '0;
        slot_y     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_x[X_W*i +: X_W] = x_q[i];
            slot_y[Y_W*i +: Y_W] = y_q[i];
        end
    end

endmodule

// File: tb/tb_note_slot_scheduler.sv
// tb/tb_note_slot_scheduler.sv - scoreboard bench for note_slot_scheduler
module tb_note_slot_scheduler;

    localparam int NS     = 8;
    localparam int K_HIT  = 0;
    localparam int K_BAD  = 1;
    localparam int K_MISS = 2;

    typedef struct {
        int kind;
        int due;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_tick;
    logic            spawn_valid;
    logic [2:0]      spawn_lane;
    logic            spawn_ready;
    logic            strum_valid;
    logic [2:0]      strum_lane;
    logic            strum_ready;
    logic            hit;
    logic            bad_strum;
    logic            miss;
    logic            busy;
    logic [NS-1:0]   slot_valid;
    logic [NS*10-1:0] slot_x;
    logic [NS*9-1:0]  slot_y;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   miss_seen = 0;
    int   mon_kind;
    ev_t  mon_e;
    ev_t  exp_q[$];

    note_slot_scheduler #(.NUM_SLOTS(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .strum_valid (strum_valid),
        .strum_lane  (strum_lane),
        .strum_ready (strum_ready),
        .hit         (hit),
        .bad_strum   (bad_strum),
        .miss        (miss),
        .busy        (busy),
        .slot_valid  (slot_valid),
        .slot_x      (slot_x),
        .slot_y      (slot_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every hit/bad_strum/miss pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (hit && bad_strum) begin
            total++;
            bad++;
            $display("FAIL both_pulses: hit=%0b bad_strum=%0b required at most one", hit, bad_strum);
        end
        if (hit || bad_strum || miss) begin
            mon_kind = hit ? K_HIT : (bad_strum ? K_BAD : K_MISS);
            if (miss) miss_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: kind=%0d at cycle %0d, none expected", mon_kind, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind !== mon_kind || (mon_e.due >= 0 && mon_e.due != cyc)) begin
                    bad++;
                    $display("FAIL pulse_event: kind=%0d cycle=%0d required kind=%0d cycle=%0d",
                             mon_kind, cyc, mon_e.kind, mon_e.due);
                end
            end
        end
    end

    function automatic logic [9:0] sx(input int i);
        return slot_x[10*i +: 10];
    endfunction

    function automatic logic [8:0] sy(input int i);
        return slot_y[9*i +: 9];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        spawn_valid = 1'b0;
        spawn_lane = '0;
        strum_valid = 1'b0;
        strum_lane = '0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        miss_seen = 0;
    endtask

    task automatic wait_idle(input string who);
        int n = 0;
        while (!strum_ready && n < 40) begin
            step();
            n++;
        end
        total++;
        if (!strum_ready) begin
            bad++;
            $display("FAIL %s_idle_timeout: strum_ready=%0b required=1", who, strum_ready);
        end
    endtask

    task automatic do_frame();
        int n = 0;
        wait_idle("frame");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL advance_timeout: busy=%0b required=0", busy);
        end
    endtask

    task automatic do_spawn(input logic [2:0] lane);
        int n = 0;
        while (!spawn_ready && n < 40) begin
            step();
            n++;
        end
        total++;
        if (!spawn_ready) begin
            bad++;
            $display("FAIL spawn_ready_timeout: spawn_ready=%0b required=1", spawn_ready);
        end
        spawn_valid = 1'b1;
        spawn_lane = lane;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic do_strum(input logic [2:0] lane, input int kind);
        int n = 0;
        wait_idle("strum");
        strum_valid = 1'b1;
        strum_lane = lane;
        exp_q.push_back('{kind, cyc + 9});
        step();
        strum_valid = 1'b0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL strum_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (slot_valid !== '0 || slot_x !== '0 || slot_y !== '0) begin
            bad++;
            $display("FAIL reset_slots: valid=%0h x=%0h y=%0h required all 0", slot_valid, slot_x, slot_y);
        end
        total++;
        if ({busy, hit, bad_strum, miss} !== 4'b0000 || spawn_ready !== 1'b1 || strum_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: busy/hit/bad/miss=%b spawn_ready=%b strum_ready=%b required 0000 1 1",
                     {busy, hit, bad_strum, miss}, spawn_ready, strum_ready);
        end
        do_spawn(3'd2);
        total++;
        if (slot_valid !== 8'h01 || sx(0) !== 10'd288 || sy(0) !== 9'd0 || spawn_ready !== 1'b1) begin
            bad++;
            $display("FAIL spawn_lane2: valid=%0h x=%0d y=%0d ready=%b required 01 288 0 1",
                     slot_valid, sx(0), sy(0), spawn_ready);
        end
        do_spawn(3'd6);
        total++;
        if (slot_valid !== 8'h01) begin
            bad++;
            $display("FAIL spawn_bad_lane: valid=%0h required=01", slot_valid);
        end
    endtask

    task automatic test_pool_full();
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) do_spawn(3'(i));
        for (int f = 0; f < 200; f++) do_frame();
        do_spawn(3'd4);
        do_spawn(3'd0);
        do_spawn(3'd1);
        do_spawn(3'd2);
        total++;
        if (slot_valid !== 8'hFF || spawn_ready !== 1'b0 || sy(2) !== 9'd400) begin
            bad++;
            $display("FAIL pool_full: valid=%0h ready=%b y2=%0d required FF 0 400", slot_valid, spawn_ready, sy(2));
        end
        spawn_valid = 1'b1;
        spawn_lane = 3'd4;
        repeat (3) step();
        total++;
        if (slot_valid !== 8'hFF || spawn_ready !== 1'b0) begin
            bad++;
            $display("FAIL pool_hold: valid=%0h ready=%b required FF 0", slot_valid, spawn_ready);
        end
        do_strum(3'd2, K_HIT);
        while (!spawn_ready && n < 20) begin
            step();
            n++;
        end
        step();
        spawn_valid = 1'b0;
        total++;
        if (slot_valid !== 8'hFF || sx(2) !== 10'd416 || sy(2) !== 9'd0) begin
            bad++;
            $display("FAIL pool_refill: valid=%0h x2=%0d y2=%0d required FF 416 0", slot_valid, sx(2), sy(2));
        end
    endtask

    task automatic test_miss();
        do_reset();
        do_spawn(3'd0);
        for (int f = 0; f < 239; f++) do_frame();
        total++;
        if (slot_valid !== 8'h01 || sy(0) !== 9'd478 || miss_seen != 0) begin
            bad++;
            $display("FAIL pre_retire: valid=%0h y=%0d misses=%0d required 01 478 0", slot_valid, sy(0), miss_seen);
        end
        exp_q.push_back('{K_MISS, -1});
        do_frame();
        total++;
        if (slot_valid !== 8'h00 || miss_seen != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL retire: valid=%0h misses=%0d pending=%0d required 00 1 0",
                     slot_valid, miss_seen, exp_q.size());
        end
    endtask

    task automatic test_hit_window();
        do_reset();
        do_spawn(3'd1);
        for (int f = 0; f < 8; f++) do_frame();
        do_spawn(3'd1);
        for (int f = 0; f < 202; f++) do_frame();
        total++;
        if (sy(0) !== 9'd420 || sy(1) !== 9'd404 || slot_valid !== 8'h03) begin
            bad++;
            $display("FAIL hit_setup: y0=%0d y1=%0d valid=%0h required 420 404 03", sy(0), sy(1), slot_valid);
        end
        do_strum(3'd1, K_HIT);
        total++;
        if (slot_valid !== 8'h02) begin
            bad++;
            $display("FAIL hit_lowest: valid=%0h required=02", slot_valid);
        end
        do_strum(3'd3, K_BAD);
        total++;
        if (slot_valid !== 8'h02) begin
            bad++;
            $display("FAIL bad_strum_keep: valid=%0h required=02", slot_valid);
        end
        do_strum(3'd1, K_HIT);
        total++;
        if (slot_valid !== 8'h00) begin
            bad++;
            $display("FAIL hit_second: valid=%0h required=00", slot_valid);
        end
    endtask

    task automatic test_tick_pend();
        int t0;
        int n = 0;
        do_reset();
        do_spawn(3'd0);
        wait_idle("pend");
        t0 = cyc;
        strum_valid = 1'b1;
        strum_lane = 3'd3;
        exp_q.push_back('{K_BAD, t0 + 9});
        step();
        strum_valid = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        total++;
        if (cyc != t0 + 10 || spawn_ready !== 1'b0 || strum_ready !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL pend_idle: cycle=%0d sr=%b tr=%b pending=%0d required %0d 0 0 0",
                     cyc - t0, spawn_ready, strum_ready, exp_q.size(), 10);
        end
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL pend_advance_start: busy=%b required=1", busy);
        end
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        repeat (12) step();
        total++;
        if (sy(0) !== 9'd2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pend_coalesce: y=%0d busy=%b required 2 0", sy(0), busy);
        end
    endtask

    task automatic test_reset_mid_advance();
        do_reset();
        for (int i = 0; i < 4; i++) do_spawn(3'(i));
        wait_idle("mid");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (slot_valid !== '0 || slot_y !== '0 || slot_x !== '0) begin
            bad++;
            $display("FAIL mid_reset_slots: valid=%0h x=%0h y=%0h required all 0", slot_valid, slot_x, slot_y);
        end
        total++;
        if ({busy, hit, bad_strum, miss} !== 4'b0000 || spawn_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ctrl: busy/hit/bad/miss=%b spawn_ready=%b required 0000 1",
                     {busy, hit, bad_strum, miss}, spawn_ready);
        end
    endtask

    initial begin
        test_reset();
        test_pool_full();
        test_miss();
        test_hit_window();
        test_tick_pend();
        test_reset_mid_advance();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
